frame_cmd_sequencer: RTL and testbench

FRAME_CMD_SEQUENCER -- requirements
Module: frame_cmd_sequencer

---
 rtl/frame_cmd_sequencer.sv | 168 ++++++++++++++++
 tb/tb_frame_cmd_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_cmd_sequencer.sv
// frame_cmd_sequencer
//   Buffers triangle / end-of-frame commands in a small FIFO and sequences
//   them to the draw engine, the screen-clear unit and the pixel buffer
//   controller. A clear is issued before the first command of every frame,
//   and each EOF swaps the draw target between the two frame buffers.
//
// Ports
//   sys_clk, reset          clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command push handshake (ready = FIFO not full)
//   cmd_op                  0=TRI, 1=EOF, 2/3 reserved (discarded)
//   cmd_ax..cmd_cy          triangle vertices, cmd_colour triangle colour
//   draw_en/draw_done       draw start pulse / completion pulse
//   opcode, ax..cy, colour  latched draw operands (opcode fixed at 1)
//   clear_start/clear_done  screen clear request / completion pulse
//   swap_buffer/swap_done   buffer swap request / completion (vblank)
//   base_addr               current draw-target buffer offset
//   frame_count             completed frames (wraps)
//   busy                    sequencer active or commands pending
module frame_cmd_sequencer #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BUF_A_ADDR = 32'h0012C000,
  parameter logic [31:0] BUF_B_ADDR = 32'h00000000
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_ax,
  input  logic [15:0] cmd_ay,
  input  logic [15:0] cmd_bx,
  input  logic [15:0] cmd_by,
  input  logic [15:0] cmd_cx,
  input  logic [15:0] cmd_cy,
  input  logic [31:0] cmd_colour,
  output logic        draw_en,
  output logic [3:0]  opcode,
  output logic [15:0] ax,
  output logic [15:0] ay,
  output logic [15:0] bx,
  output logic [15:0] by,
  output logic [15:0] cx,
  output logic [15:0] cy,
  output logic [31:0] colour,
  input  logic        draw_done,
  output logic        clear_start,
  input  logic        clear_done,
  output logic        swap_buffer,
  input  logic        swap_done,
  output logic [31:0] base_addr,
  output logic [15:0] frame_count,
  output logic        busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] OP_TRI = 2'd0;
  localparam logic [1:0] OP_EOF = 2'd1;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] ax, ay, bx, by, cx, cy;
    logic [31:0] colour;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE, CLEAR, WAIT_CLEAR, ISSUE, WAIT_DRAW, WAIT_SWAP
  } state_t;

  state_t state, state_n;

  // command FIFO
  cmd_t          mem [FIFO_DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop;
  logic          need_clear;
  logic          buf_sel;

  assign cmd_ready = (count != (PW+1)'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  // ISSUE is only entered with a non-empty FIFO, so this never pops empty.
  assign pop       = (state == ISSUE);
  assign head      = mem[rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= '{cmd_op, cmd_ax, cmd_ay, cmd_bx, cmd_by,
                               cmd_cx, cmd_cy, cmd_colour};
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // sequencer
  always_ff @(posedge sys_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    clear_start = 1'b0;
    case (state)
      IDLE:       if (count != '0) state_n = need_clear ? CLEAR : ISSUE;
      CLEAR: begin
        clear_start = 1'b1;
        state_n     = clear_done ? IDLE : WAIT_CLEAR;
      end
      WAIT_CLEAR: if (clear_done) state_n = IDLE;
      ISSUE: begin
        case (head.op)
          OP_TRI:  state_n = WAIT_DRAW;
          OP_EOF:  state_n = WAIT_SWAP;
          default: state_n = IDLE;
        endcase
      end
      WAIT_DRAW:  if (draw_done) state_n = IDLE;
      WAIT_SWAP:  if (swap_done) state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // Start pulses are registered off the ISSUE decision, so they coincide
  // with the first cycle of the matching wait state.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      draw_en     <= 1'b0;
      swap_buffer <= 1'b0;
      need_clear  <= 1'b1;
      buf_sel     <= 1'b0;
      frame_count <= '0;
      ax <= '0; ay <= '0; bx <= '0; by <= '0; cx <= '0; cy <= '0;
      colour <= '0;
    end else begin
      draw_en     <= (state == ISSUE) && (head.op == OP_TRI);
      swap_buffer <= (state == ISSUE) && (head.op == OP_EOF);
      if ((state == ISSUE) && (head.op == OP_TRI)) begin
        ax <= head.ax; ay <= head.ay; bx <= head.bx; by <= head.by;
        cx <= head.cx; cy <= head.cy; colour <= head.colour;
      end
      // dones only count inside the state that is waiting for them
      if ((state == CLEAR || state == WAIT_CLEAR) && clear_done)
        need_clear <= 1'b0;
      if ((state == WAIT_SWAP) && swap_done) begin
        need_clear  <= 1'b1;
        buf_sel     <= ~buf_sel;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  assign base_addr = buf_sel ? BUF_B_ADDR : BUF_A_ADDR;
  assign opcode    = 4'd1;
  assign busy      = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_frame_cmd_sequencer.sv
// Directed bench for frame_cmd_sequencer: each task drives one scenario and
// checks outputs against hand-computed values a little after each rising edge.
module tb_frame_cmd_sequencer;
  localparam logic [31:0] A_ADDR = 32'h0012C000;
  localparam logic [31:0] B_ADDR = 32'h00000000;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [15:0] cmd_ax = '0, cmd_ay = '0, cmd_bx = '0, cmd_by = '0, cmd_cx = '0, cmd_cy = '0;
  logic [31:0] cmd_colour = '0;
  logic        draw_en;
  logic [3:0]  opcode;
  logic [15:0] ax, ay, bx, by, cx, cy;
  logic [31:0] colour;
  logic        draw_done = 1'b0, clear_start, clear_done = 1'b0;
  logic        swap_buffer, swap_done = 1'b0;
  logic [31:0] base_addr;
  logic [15:0] frame_count;
  logic        busy;

  int total = 0, bad = 0;
  int cyc = 0, n_draw, n_clear, n_swap, f_draw, f_clear, f_swap;
  bit auto_draw = 0, auto_clear = 0, auto_swap = 0;

  frame_cmd_sequencer dut (
    .sys_clk(sys_clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ax(cmd_ax), .cmd_ay(cmd_ay), .cmd_bx(cmd_bx), .cmd_by(cmd_by),
    .cmd_cx(cmd_cx), .cmd_cy(cmd_cy), .cmd_colour(cmd_colour), .draw_en(draw_en),
    .opcode(opcode), .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy), .colour(colour),
    .draw_done(draw_done), .clear_start(clear_start), .clear_done(clear_done),
    .swap_buffer(swap_buffer), .swap_done(swap_done), .base_addr(base_addr),
    .frame_count(frame_count), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  // one clock; afterwards count pulses and, if enabled, answer them on the next edge
  task automatic step();
    @(posedge sys_clk); #1;
    cyc++;
    if (draw_en)     begin n_draw++;  if (f_draw  < 0) f_draw  = cyc; end
    if (clear_start) begin n_clear++; if (f_clear < 0) f_clear = cyc; end
    if (swap_buffer) begin n_swap++;  if (f_swap  < 0) f_swap  = cyc; end
    draw_done  = auto_draw  && draw_en;
    clear_done = auto_clear && clear_start;
    swap_done  = auto_swap  && swap_buffer;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    n_draw = 0; n_clear = 0; n_swap = 0; f_draw = -1; f_clear = -1; f_swap = -1;
  endtask

  task automatic push(input logic [1:0] op, input logic [15:0] a0, a1, b0, b1, c0, c1,
                      input logic [31:0] col);
    cmd_valid = 1'b1; cmd_op = op;
    cmd_ax = a0; cmd_ay = a1; cmd_bx = b0; cmd_by = b1; cmd_cx = c0; cmd_cy = c1;
    cmd_colour = col;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    auto_draw = 0; auto_clear = 0; auto_swap = 0;
    cmd_valid = 0; draw_done = 0; clear_done = 0; swap_done = 0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if ({draw_en, clear_start, swap_buffer} !== 3'b000) begin bad++;
      $display("FAIL rst_pulses got=%b exp=000", {draw_en, clear_start, swap_buffer}); end
    total++; if (base_addr !== A_ADDR) begin bad++; $display("FAIL rst_base got=%h exp=%h", base_addr, A_ADDR); end
    total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL rst_fc got=%0d exp=0", frame_count); end
    total++; if ({ax, ay, bx, by, cx, cy, colour} !== 128'd0) begin bad++; $display("FAIL rst_operands not zero ax=%0d colour=%h", ax, colour); end
  endtask

  task automatic test_first_tri();
    do_reset();
    push(2'd0, 16'd100, 16'd100, 16'd150, 16'd100, 16'd100, 16'd150, 32'hFFFF0000);
    step();
    total++; if (clear_start !== 1'b1) begin bad++; $display("FAIL first_clear got=%b exp=1", clear_start); end
    step();
    total++; if (clear_start !== 1'b0) begin bad++; $display("FAIL clear_one_cycle got=%b exp=0", clear_start); end
    clear_done = 1'b1;
    step();                       // back in IDLE
    step();
    total++; if (draw_en !== 1'b0) begin bad++; $display("FAIL draw_early got=%b exp=0", draw_en); end
    step();
    total++; if (draw_en !== 1'b1) begin bad++; $display("FAIL draw_latency got=%b exp=1", draw_en); end
    total++; if ({ax, ay, bx, by, cx, cy} !== {16'd100, 16'd100, 16'd150, 16'd100, 16'd100, 16'd150}) begin bad++;
      $display("FAIL first_operands got=%0d,%0d,%0d,%0d,%0d,%0d exp=100,100,150,100,100,150", ax, ay, bx, by, cx, cy); end
    total++; if (colour !== 32'hFFFF0000 || opcode !== 4'd1) begin bad++;
      $display("FAIL first_colour_op got=%h/%0d exp=ffff0000/1", colour, opcode); end
    step();
    total++; if (draw_en !== 1'b0 || ax !== 16'd100) begin bad++; $display("FAIL draw_pulse_hold got=%b/%0d exp=0/100", draw_en, ax); end
    draw_done = 1'b1;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL first_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < 8; i++) push(2'd0, 16'(10 + i), 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", cmd_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy got=%b exp=1", busy); end
    clear_done = 1'b1;
    step(); step(); step();
    total++; if (draw_en !== 1'b1 || ax !== 16'd10) begin bad++; $display("FAIL order0 draw=%b ax=%0d exp=1/10", draw_en, ax); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL seven_ready got=%b exp=1", cmd_ready); end
    draw_done = 1'b1;
    step(); step();               // IDLE, then ISSUE
    push(2'd0, 16'd99, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0);   // push+pop with 7 queued
    total++; if (draw_en !== 1'b1 || ax !== 16'd11) begin bad++; $display("FAIL order1 draw=%b ax=%0d exp=1/11", draw_en, ax); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL pushpop_ready got=%b exp=1", cmd_ready); end
    push(2'd0, 16'd98, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL pushpop_count got=%b exp=0 (count should reach 8)", cmd_ready); end
  endtask

  task automatic test_frame();
    do_reset();
    auto_draw = 1; auto_clear = 1; auto_swap = 1;
    clear_counts();
    push(2'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 32'h11);
    push(2'd0, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12, 32'h22);
    push(2'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0);
    run(40);
    total++; if (n_draw !== 2 || n_swap !== 1 || n_clear !== 1) begin bad++;
      $display("FAIL frame_pulses got draw=%0d swap=%0d clear=%0d exp=2/1/1", n_draw, n_swap, n_clear); end
    total++; if (base_addr !== B_ADDR || frame_count !== 16'd1) begin bad++;
      $display("FAIL frame_swap got base=%h fc=%0d exp=%h/1", base_addr, frame_count, B_ADDR); end
    total++; if (ax !== 16'd7 || colour !== 32'h22) begin bad++; $display("FAIL frame_last_op got ax=%0d col=%h exp=7/22", ax, colour); end
    clear_counts();
    push(2'd0, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 32'h33);
    run(20);
    total++; if (n_clear !== 1 || n_draw !== 1 || !(f_clear >= 0 && f_clear < f_draw)) begin bad++;
      $display("FAIL newframe_clear got clear=%0d draw=%0d at %0d/%0d exp clear first", n_clear, n_draw, f_clear, f_draw); end
  endtask

  task automatic test_two_swaps();
    clear_counts();
    push(2'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0);
    run(20);
    total++; if (n_swap !== 1 || n_clear !== 0) begin bad++; $display("FAIL swap2_pulses got swap=%0d clear=%0d exp=1/0", n_swap, n_clear); end
    total++; if (base_addr !== A_ADDR || frame_count !== 16'd2) begin bad++;
      $display("FAIL swap2_state got base=%h fc=%0d exp=%h/2", base_addr, frame_count, A_ADDR); end
    auto_draw = 0; auto_clear = 0; auto_swap = 0;
    clear_counts();
    draw_done = 1'b1;  step();
    swap_done = 1'b1;  step();
    clear_done = 1'b1; step();
    step();
    total++; if (busy !== 1'b0 || n_draw !== 0 || frame_count !== 16'd2 || base_addr !== A_ADDR) begin bad++;
      $display("FAIL stray_done got busy=%b draw=%0d fc=%0d base=%h exp=0/0/2/%h", busy, n_draw, frame_count, base_addr, A_ADDR); end
    auto_draw = 1; auto_clear = 1; auto_swap = 1;
    clear_counts();
    push(2'd0, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 32'h44);
    run(20);
    total++; if (n_clear !== 1 || n_draw !== 1) begin bad++; $display("FAIL stray_clear_ignored got clear=%0d draw=%0d exp=1/1", n_clear, n_draw); end
  endtask

  task automatic test_eof_first();
    do_reset();
    auto_draw = 1; auto_clear = 1; auto_swap = 1;
    clear_counts();
    push(2'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0);
    run(20);
    total++; if (n_clear !== 1 || n_swap !== 1 || !(f_clear >= 0 && f_clear < f_swap)) begin bad++;
      $display("FAIL eof_first got clear=%0d swap=%0d at %0d/%0d exp clear first", n_clear, n_swap, f_clear, f_swap); end
    total++; if (frame_count !== 16'd1 || base_addr !== B_ADDR) begin bad++;
      $display("FAIL eof_first_state got fc=%0d base=%h exp=1/%h", frame_count, base_addr, B_ADDR); end
  endtask

  task automatic test_reserved();
    do_reset();
    auto_draw = 1; auto_clear = 1; auto_swap = 1;
    clear_counts();
    push(2'd3, 16'd77, 16'd77, 16'd77, 16'd77, 16'd77, 16'd77, 32'h77);
    run(20);
    total++; if (n_clear !== 1 || n_draw !== 0 || n_swap !== 0 || busy !== 1'b0) begin bad++;
      $display("FAIL rsv3 got clear=%0d draw=%0d swap=%0d busy=%b exp=1/0/0/0", n_clear, n_draw, n_swap, busy); end
    total++; if (ax !== 16'd0 || frame_count !== 16'd0) begin bad++; $display("FAIL rsv3_latch got ax=%0d fc=%0d exp=0/0", ax, frame_count); end
    clear_counts();
    push(2'd2, 16'd66, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0);
    run(20);
    total++; if (n_clear !== 0 || n_draw !== 0 || n_swap !== 0 || busy !== 1'b0) begin bad++;
      $display("FAIL rsv2 got clear=%0d draw=%0d swap=%0d busy=%b exp=0/0/0/0", n_clear, n_draw, n_swap, busy); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    auto_clear = 1; auto_swap = 1; auto_draw = 0;
    clear_counts();
    push(2'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0);
    for (int i = 0; i < 4; i++) push(2'd0, 16'(40 + i), 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 32'h55);
    run(30);
    total++; if (n_draw !== 1 || n_clear !== 2 || frame_count !== 16'd1 || busy !== 1'b1) begin bad++;
      $display("FAIL midrst_setup got draw=%0d clear=%0d fc=%0d busy=%b exp=1/2/1/1", n_draw, n_clear, frame_count, busy); end
    do_reset();
    total++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || frame_count !== 16'd0 || base_addr !== A_ADDR || ax !== 16'd0) begin bad++;
      $display("FAIL midrst_vals got ready=%b busy=%b fc=%0d base=%h ax=%0d exp=1/0/0/%h/0", cmd_ready, busy, frame_count, base_addr, ax, A_ADDR); end
    clear_counts();
    draw_done = 1'b1;
    step();
    auto_draw = 1; auto_clear = 1; auto_swap = 1;
    run(20);
    total++; if (n_draw !== 0 || n_clear !== 0 || n_swap !== 0 || busy !== 1'b0) begin bad++;
      $display("FAIL midrst_flush got draw=%0d clear=%0d swap=%0d busy=%b exp=0/0/0/0", n_draw, n_clear, n_swap, busy); end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_first_tri();
    test_fifo_full();
    test_frame();
    test_two_swaps();
    test_eof_first();
    test_reserved();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
